// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement adder/subtractor: carry chain split into STAGES registered
// slices with a global-stall valid/ready handshake. Define ADDSUB_SAT_EN for the saturate port.
module pipelined_addsub #(
    parameter int WIDTH  = 64,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
`ifdef ADDSUB_SAT_EN
    input  logic             saturate,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             negative,
    output logic             zero,
    output logic             carryout,
    output logic             overflow
);

    localparam int SW = WIDTH / STAGES;

    logic advance;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    for (genvar k = 0; k < STAGES; k++) begin : stg
        // Stage k sees only the operand bits not yet consumed and the result bits already produced.
        localparam int IN_W = WIDTH - k * SW;
        localparam int LO   = (k + 1) * SW;

        logic [IN_W-1:0] a_i;
        logic [IN_W-1:0] bp_i;
        logic            c_i;
        logic            v_i;
`ifdef ADDSUB_SAT_EN
        logic            sat_i;
`endif
        logic [SW:0]     sum;
        logic [LO-1:0]   res_n;

        assign sum = {1'b0, a_i[SW-1:0]} + {1'b0, bp_i[SW-1:0]} + {{SW{1'b0}}, c_i};

        if (k == 0) begin : src
            assign a_i   = a;
            assign bp_i  = sub ? ~b : b;
            assign c_i   = sub;
            assign v_i   = in_valid;
`ifdef ADDSUB_SAT_EN
            assign sat_i = saturate;
`endif
            assign res_n = sum[SW-1:0];
        end else begin : src
            assign a_i   = stg[k-1].mid.a_q;
            assign bp_i  = stg[k-1].mid.bp_q;
            assign c_i   = stg[k-1].mid.c_q;
            assign v_i   = stg[k-1].mid.v_q;
`ifdef ADDSUB_SAT_EN
            assign sat_i = stg[k-1].mid.sat_q;
`endif
            assign res_n = {sum[SW-1:0], stg[k-1].mid.res_q};
        end

        if (k < STAGES - 1) begin : mid
            logic [IN_W-SW-1:0] a_q;
            logic [IN_W-SW-1:0] bp_q;
            logic [LO-1:0]      res_q;
            logic               c_q;
            logic               v_q;
`ifdef ADDSUB_SAT_EN
            logic               sat_q;
`endif

            always_ff @(posedge clk) begin
                if (reset) begin
                    v_q <= 1'b0;
                end else if (advance) begin
                    v_q <= v_i;
                end
            end

            always_ff @(posedge clk) begin
                if (advance) begin
                    a_q   <= a_i[IN_W-1:SW];
                    bp_q  <= bp_i[IN_W-1:SW];
                    res_q <= res_n;
                    c_q   <= sum[SW];
`ifdef ADDSUB_SAT_EN
                    sat_q <= sat_i;
`endif
                end
            end
        end else begin : fin
            logic             a_msb;
            logic             b_msb;
            logic             ovf_n;
            logic [WIDTH-1:0] res_f;

            assign a_msb = a_i[IN_W-1];
            assign b_msb = bp_i[IN_W-1];
            assign ovf_n = (a_msb == b_msb) && (res_n[WIDTH-1] != a_msb);
`ifdef ADDSUB_SAT_EN
            // Overflow direction follows A's sign: positive clamps to max, negative to min.
            assign res_f = (sat_i && ovf_n) ? {a_msb, {(WIDTH-1){~a_msb}}} : res_n;
`else
            assign res_f = res_n;
`endif

            always_ff @(posedge clk) begin
                if (reset) begin
                    out_valid <= 1'b0;
                    result    <= '0;
                    negative  <= 1'b0;
                    zero      <= 1'b0;
                    carryout  <= 1'b0;
                    overflow  <= 1'b0;
                end else if (advance) begin
                    out_valid <= v_i;
                    result    <= res_f;
                    negative  <= res_f[WIDTH-1];
                    zero      <= (res_f == '0);
                    carryout  <= sum[SW];
                    overflow  <= ovf_n;
                end
            end
        end
    end

endmodule

// File: tb/tb_pipelined_addsub.sv
// Scoreboard bench for pipelined_addsub: directed vectors, stall, and mid-flight reset.
// Saturation vectors are exercised when ADDSUB_SAT_EN is defined.
module tb_pipelined_addsub;
    localparam int WIDTH  = 64;
    localparam int STAGES = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
`ifdef ADDSUB_SAT_EN
    logic             saturate;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             negative;
    logic             zero;
    logic             carryout;
    logic             overflow;

    always #5 clk = ~clk;

    pipelined_addsub #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .a(a),
        .b(b),
        .sub(sub),
`ifdef ADDSUB_SAT_EN
        .saturate(saturate),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result(result),
        .negative(negative),
        .zero(zero),
        .carryout(carryout),
        .overflow(overflow)
    );

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        sub;
        logic        sat;
        logic [63:0] res;
        logic        n, z, c, v;
    } vec_t;

    typedef struct {
        logic [63:0] res;
        logic        n, z, c, v;
    } exp_t;

    vec_t vecs[8];
    exp_t sb[$];
    int   errors   = 0;
    int   checks   = 0;
    int   issued   = 0;
    int   received = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    task automatic send(input vec_t v, input bit track);
        int   n   = 0;
        bit   acc = 1'b0;
        exp_t e;
        a        = v.a;
        b        = v.b;
        sub      = v.sub;
`ifdef ADDSUB_SAT_EN
        saturate = v.sat;
`endif
        in_valid = 1'b1;
        if (track) begin
            e.res = v.res; e.n = v.n; e.z = v.z; e.c = v.c; e.v = v.v;
            sb.push_back(e);
            issued++;
        end
        while (!acc && n < 100) begin
            @(posedge clk);
            acc = in_ready;
            n++;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready 0 expected 1 within 100 cycles");
        end
        #1 in_valid = 1'b0;
    endtask

    // Called 1 time unit after the capture edge; inputs were driven one edge earlier.
    task automatic expect_latency(input string name);
        int lat = 0;
        @(negedge clk);
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check(name, 64'(lat + 1), 64'(STAGES));
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got result 0x%h expected no output", result);
                end else begin
                    e = sb.pop_front();
                    received++;
                    check("result", result, e.res);
                    check("negative", 64'(negative), 64'(e.n));
                    check("zero", 64'(zero), 64'(e.z));
                    check("carryout", 64'(carryout), 64'(e.c));
                    check("overflow", 64'(overflow), 64'(e.v));
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        vecs[0] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h0,                   1'b0, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{64'd5,                   64'd5, 1'b1, 1'b0, 64'h0,                   1'b0, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{64'd3,                   64'd5, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h0000_0001_0000_0000, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[6] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b1, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b1, 1'b1};

        reset     = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        sub       = 1'b0;
`ifdef ADDSUB_SAT_EN
        saturate  = 1'b0;
`endif
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result", result, 64'd0);
        check("rst_negative", 64'(negative), 64'd0);
        check("rst_zero", 64'(zero), 64'd0);
        check("rst_carryout", 64'(carryout), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);

        @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) begin
            send(vecs[i], 1'b1);
            expect_latency($sformatf("latency_v%0d", i));
            repeat (2) @(posedge clk);
            #1;
        end
`ifdef ADDSUB_SAT_EN
        for (int i = 6; i < 8; i++) begin
            send(vecs[i], 1'b1);
            expect_latency($sformatf("latency_sat_v%0d", i));
            repeat (2) @(posedge clk);
            #1;
        end
`endif
        repeat (4) @(posedge clk);
        #1;

        // Six back-to-back ops; consumer stalls for 3 edges once the first result shows.
        fork
            begin
                for (int i = 0; i < 6; i++) send(vecs[i], 1'b1);
            end
            begin
                int n = 0;
                @(posedge clk);
                #1;
                while (!out_valid && n < 20) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                check("stall_first_valid", 64'(out_valid), 64'd1);
                out_ready = 1'b0;
                #1;
                check("full_in_ready", 64'(in_ready), 64'd0);
                for (int s = 0; s < 3; s++) begin
                    @(posedge clk);
                    #1;
                    check($sformatf("stall%0d_out_valid", s), 64'(out_valid), 64'd1);
                    check($sformatf("stall%0d_result", s), result, vecs[0].res);
                    check($sformatf("stall%0d_in_ready", s), 64'(in_ready), 64'd0);
                end
                out_ready = 1'b1;
                for (int s = 0; s < 5; s++) begin
                    @(posedge clk);
                    #1;
                    check($sformatf("resume%0d_out_valid", s), 64'(out_valid), 64'd1);
                end
            end
        join
        repeat (10) @(posedge clk);
        #1;

        // Three ops in flight are flushed by a one-cycle reset pulse.
        for (int i = 0; i < 3; i++) send(vecs[i], 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            check($sformatf("flush%0d_out_valid", s), 64'(out_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        send(vecs[3], 1'b1);
        expect_latency("latency_after_reset");

        repeat (10) @(posedge clk);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        check("received_count", 64'(received), 64'(issued));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
